csr_row_sequencer: RTL
======================

// Module: csr_row_sequencer
// PURPOSE
//  Walks one CSR sparse matrix row by row and issues nonzero element slots to the MAC datapath.
//  Fetches row pointers from the row-pointer memory.
//  Drives the enable of the global nonzero-index counter_up instance (nz_en).
//  Consumes that counter's value (nz_count) to detect row ends.
//  Sits directly upstream of counter_up; nz_count also serves as the value/column-index memory address.
// PARAMETERS
//  COUNT_LEN  10  nonzero index width is COUNT_LEN+1 bits; must match counter_up COUNT_LEN
//  ROW_W       8  row index width; row-pointer address is ROW_W+1 bits
// PORTS
//  clk        in   1            clock; all logic on posedge
//  reset      in   1            asynchronous, active-high; shared with counter_up
//  start      in   1            one-cycle pulse; begin matrix walk (accepted in IDLE only)
//  num_rows   in   ROW_W        row count; sampled on accepted start
//  rp_req     out  1            one-cycle read request to row-pointer memory
//  rp_addr    out  ROW_W+1      row-pointer address; held stable until rp_valid
//  rp_valid   in   1            read data valid; arrives >=1 cycle after rp_req
//  rp_data    in   COUNT_LEN+1  row-pointer value
//  nz_count   in   COUNT_LEN+1  current value of counter_up.count
//  nz_en      out  1            enable to counter_up; combinational: nz_valid & nz_ready
//  nz_valid   out  1            nonzero slot valid to MAC
//  nz_ready   in   1            MAC accepts slot
//  nz_row     out  ROW_W        row index of current slot / row_done
//  nz_last    out  1            current slot is last nonzero of its row
//  row_done   out  1            one-cycle pulse; row nz_row finished (also for empty rows)
//  busy       out  1            high in any state but IDLE
//  done       out  1            one-cycle pulse; walk complete
//  err        out  1            sticky; pointer inconsistency; cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; row reg r=0; end_ptr=0.
//  FSM states: IDLE, FETCH0, FETCH, STREAM, ROWDONE, DONE.
//  IDLE
//   - start && num_rows==0 -> DONE.
//   - start otherwise -> FETCH0, with r=0, rp_addr=0, rp_req=1 for that cycle.
//   - start in any other state is ignored.
//  FETCH0: wait rp_valid.
//   - rp_data != nz_count -> err=1, DONE.
//   - else -> FETCH; rp_addr=r+1, rp_req pulse.
//  FETCH: wait rp_valid; end_ptr<=rp_data.
//   - rp_data < nz_count -> err=1, DONE.
//   - rp_data == nz_count -> ROWDONE (empty row; no slots issued).
//   - otherwise -> STREAM.
//  STREAM: nz_valid=1, nz_row=r, nz_last=(nz_count+1 == end_ptr); width COUNT_LEN+1, no wrap allowed.
//   - nz_valid holds until handshake; nz_row stable while valid.
//   - Handshake asserts nz_en; counter_up increments at the same edge; max 1 slot/cycle.
//   - Handshake with nz_last -> ROWDONE (nz_valid low next cycle).
//  ROWDONE: row_done=1 for one cycle with nz_row=r.
//   - r==num_rows-1 -> DONE.
//   - else r<=r+1 -> FETCH with rp_addr=r+2, rp_req pulse.
//  DONE: done=1 for one cycle -> IDLE.
//  rp_valid outside FETCH0/FETCH is ignored.
//  nz_ready outside STREAM has no effect; nz_en=0 outside STREAM.
//  Mid-operation reset: immediate return to IDLE, outputs 0; counter_up clears on the same reset.
//  Latency: first slot valid 1 cycle after the rp_valid for row 0's end pointer.
//  Per-row overhead is 1 ROWDONE cycle plus 1 FETCH round-trip.
// TESTING
//  1. row_ptr={0,2,5}, num_rows=2, nz_ready=1, memory latency 1
//     -> slots nz_count 0,1 (row 0, last on 1), then 2,3,4 (row 1, last on 4).
//     -> row_done x2, done pulse, final nz_count=5.
//  2. row_ptr={0,0,3,3}, num_rows=3 -> rows 0 and 2 give row_done with no nz_valid; row 1 gives 3 slots.
//  3. Case 1 with nz_ready toggling 1,0,0,1... -> nz_valid/nz_row/nz_count held while stalled.
//     -> nz_en only on handshake; total nz_en pulses = 5.
//  4. row_ptr={0,3,2} -> row 0 streams 3 slots; FETCH sees 2<3 -> err=1, done, IDLE.
//     -> next start clears err.
//  5. Assert reset during STREAM of case 1 at nz_count=3
//     -> IDLE, nz_valid=0, busy=0, nz_count=0; restart reproduces case 1.
//  6. num_rows=0 start -> done 1 cycle later, no rp_req.
//     start pulsed while busy -> ignored.
//     rp latency 4 cycles -> rp_addr stable, same results as case 1.

Source files
------------

// File: rtl/csr_row_sequencer_if.sv
// Row-pointer fetch and nonzero-slot issue bus between the CSR row sequencer and
// its neighbours (row-pointer memory, counter_up and the MAC datapath).
interface csr_row_sequencer_if #(
  parameter int COUNT_LEN = 10,
  parameter int ROW_W     = 8
);
  logic               rp_req;
  logic [ROW_W:0]     rp_addr;
  logic               rp_valid;
  logic [COUNT_LEN:0] rp_data;
  logic [COUNT_LEN:0] nz_count;
  logic               nz_en;
  logic               nz_valid;
  logic               nz_ready;
  logic [ROW_W-1:0]   nz_row;
  logic               nz_last;
  logic               row_done;

  modport master (
    output rp_req, rp_addr, nz_en, nz_valid, nz_row, nz_last, row_done,
    input  rp_valid, rp_data, nz_count, nz_ready
  );

  modport slave (
    input  rp_req, rp_addr, nz_en, nz_valid, nz_row, nz_last, row_done,
    output rp_valid, rp_data, nz_count, nz_ready
  );
endinterface

// File: rtl/csr_row_sequencer.sv
// Walks a CSR matrix row by row: fetches row pointers, issues one nonzero slot per
// handshake and uses the external nonzero counter (nz_count) to find row ends.
module csr_row_sequencer #(
  parameter int COUNT_LEN = 10,
  parameter int ROW_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ROW_W-1:0] num_rows,
  csr_row_sequencer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int CW = COUNT_LEN + 1;

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH, STREAM, ROWDONE, DONE} state_t;

  state_t           state;
  logic [ROW_W-1:0] r;
  logic [ROW_W-1:0] nrows;
  logic [CW-1:0]    end_ptr;

  // counter_up advances on the same edge as the handshake, so nz_count is the slot index
  assign bus.nz_en   = bus.nz_valid & bus.nz_ready;
  assign bus.nz_last = bus.nz_valid && ((bus.nz_count + CW'(1)) == end_ptr);
  assign bus.nz_row  = r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      r            <= '0;
      nrows        <= '0;
      end_ptr      <= '0;
      bus.rp_req   <= 1'b0;
      bus.rp_addr  <= '0;
      bus.nz_valid <= 1'b0;
      bus.row_done <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.rp_req   <= 1'b0;
      bus.row_done <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err   <= 1'b0;
          busy  <= 1'b1;
          nrows <= num_rows;
          r     <= '0;
          if (num_rows == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bus.rp_addr <= '0;
            bus.rp_req  <= 1'b1;
            state       <= FETCH0;
          end
        end
        // row 0 start pointer must agree with where the counter already is
        FETCH0: if (bus.rp_valid) begin
          if (bus.rp_data != bus.nz_count) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bus.rp_addr <= {1'b0, r} + (ROW_W+1)'(1);
            bus.rp_req  <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: if (bus.rp_valid) begin
          end_ptr <= bus.rp_data;
          if (bus.rp_data < bus.nz_count) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (bus.rp_data == bus.nz_count) begin
            bus.row_done <= 1'b1;
            state        <= ROWDONE;
          end else begin
            bus.nz_valid <= 1'b1;
            state        <= STREAM;
          end
        end
        STREAM: if (bus.nz_ready && bus.nz_last) begin
          bus.nz_valid <= 1'b0;
          bus.row_done <= 1'b1;
          state        <= ROWDONE;
        end
        ROWDONE: begin
          if (r == nrows - ROW_W'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r           <= r + ROW_W'(1);
            bus.rp_addr <= {1'b0, r} + (ROW_W+1)'(2);
            bus.rp_req  <= 1'b1;
            state       <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
